// File: rtl/wb_arbiter.sv
// Writeback-port arbiter.
// The writeback pipe and a 2-entry in-order FIFO of multi-cycle-unit (MDU)
// results share one register-file write port. The pipe normally has priority.
// The FIFO wins when the pipe's destination collides with a buffered result,
// so that the older value lands first. The FIFO also wins when it has waited
// STARVE_LIMIT consecutive cycles without a grant. The write port and the
// commit trace are registered, so both appear one cycle after the grant.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        pipe_valid,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_dst,
  input  logic [63:0] pipe_data,
  input  logic [63:0] pipe_pc,
  output logic        pipe_stall,

  input  logic        mdu_valid,
  input  logic [4:0]  mdu_dst,
  input  logic [63:0] mdu_data,
  output logic        mdu_ready,

  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,

  output logic        commit_valid,
  output logic [63:0] commit_pc,

  output logic        busy
);

  localparam int unsigned StarveLimitU = STARVE_LIMIT;

  logic [4:0]  fifoDst  [2];
  logic [63:0] fifoData [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;
  logic [1:0]  starveCnt;

  logic        fifoFull;
  logic        fifoEmpty;
  logic        push;
  logic        pop;
  logic [1:0]  entryValid;
  logic        pipeNeeds;
  logic        hazard;
  logic        starveHit;
  logic        fifoGrant;
  logic        pipeGrant;
  logic [4:0]  headDst;
  logic [63:0] headData;

  assign fifoFull  = (count == 2'd2);
  assign fifoEmpty = (count == 2'd0);
  assign busy      = !fifoEmpty;

  // mdu_ready depends only on occupancy, never on a same-cycle pop,
  // so the MDU side has no combinational path from the pipe inputs.
  assign mdu_ready = !fifoFull;
  assign push      = mdu_valid & mdu_ready;

  assign headDst   = fifoDst[rdPtr];
  assign headData  = fifoData[rdPtr];

  // Mark which physical slots hold live results, for the hazard compare.
  always_comb begin
    entryValid = 2'b00;
    if (count == 2'd2) begin
      entryValid = 2'b11;
    end else if (count == 2'd1) begin
      entryValid[rdPtr] = 1'b1;
    end
  end

  // The pipe competes for the port only when it really writes a register.
  // Writes to x0 are dropped and commit without any port use.
  assign pipeNeeds = pipe_valid & pipe_regwrite & (pipe_dst != 5'd0);

  assign hazard = pipeNeeds &
                  ((entryValid[0] & (fifoDst[0] == pipe_dst)) |
                   (entryValid[1] & (fifoDst[1] == pipe_dst)));

  assign starveHit = (32'(starveCnt) >= StarveLimitU);

  // The FIFO wins when the pipe does not need the port, when an older result
  // targets the same register, or when the FIFO has been starved too long.
  // The pipe's request is held, not dropped, so a FIFO win means a stall.
  assign fifoGrant  = !fifoEmpty & (!pipeNeeds | hazard | starveHit);
  assign pipeGrant  = pipeNeeds & !fifoGrant;
  assign pipe_stall = pipeNeeds & fifoGrant;
  assign pop        = fifoGrant;

  // FIFO pointers and occupancy. A simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage. It needs no reset because the count gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoDst[wrPtr]  <= mdu_dst;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  // Count consecutive cycles in which a waiting FIFO lost the port. The counter saturates at 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= 2'd0;
    end else if (fifoEmpty || fifoGrant) begin
      starveCnt <= 2'd0;
    end else if (starveCnt != 2'd3) begin
      starveCnt <= starveCnt + 2'd1;
    end
  end

  // Registered register-file write. The address and data hold when no write
  // is issued. A popped FIFO entry with dst x0 is consumed silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 64'd0;
    end else if (pipeGrant) begin
      rf_wen   <= 1'b1;
      rf_waddr <= pipe_dst;
      rf_wdata <= pipe_data;
    end else if (fifoGrant && (headDst != 5'd0)) begin
      rf_wen   <= 1'b1;
      rf_waddr <= headDst;
      rf_wdata <= headData;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Registered commit trace for every pipe instruction accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= 64'd0;
    end else begin
      commit_valid <= pipe_valid & !pipe_stall;
      if (pipe_valid && !pipe_stall) begin
        commit_pc <= pipe_pc;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. Expected register writes are queued in
// the order they must appear. Every cycle in which rf_wen is high pops and
// compares one queued write.
module tb_wb_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wrEntry_t;

  logic        clk;
  logic        reset;
  logic        pipeValid;
  logic        pipeRegwrite;
  logic [4:0]  pipeDst;
  logic [63:0] pipeData;
  logic [63:0] pipePc;
  logic        pipeStall;
  logic        mduValid;
  logic [4:0]  mduDst;
  logic [63:0] mduData;
  logic        mduReady;
  logic        rfWen;
  logic [4:0]  rfWaddr;
  logic [63:0] rfWdata;
  logic        commitValid;
  logic [63:0] commitPc;
  logic        busy;

  wrEntry_t expQ[$];
  int total;
  int bad;

  wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_valid   (pipeValid),
    .pipe_regwrite(pipeRegwrite),
    .pipe_dst     (pipeDst),
    .pipe_data    (pipeData),
    .pipe_pc      (pipePc),
    .pipe_stall   (pipeStall),
    .mdu_valid    (mduValid),
    .mdu_dst      (mduDst),
    .mdu_data     (mduData),
    .mdu_ready    (mduReady),
    .rf_wen       (rfWen),
    .rf_waddr     (rfWaddr),
    .rf_wdata     (rfWdata),
    .commit_valid (commitValid),
    .commit_pc    (commitPc),
    .busy         (busy)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison, counted, with its failure reported.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic pv, input logic rw, input logic [4:0] pdst,
                               input logic [63:0] pdata, input logic [63:0] pc,
                               input logic mv, input logic [4:0] mdst,
                               input logic [63:0] mdata);
    pipeValid    = pv;
    pipeRegwrite = rw;
    pipeDst      = pdst;
    pipeData     = pdata;
    pipePc       = pc;
    mduValid     = mv;
    mduDst       = mdst;
    mduData      = mdata;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [63:0] data);
    wrEntry_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Advance one clock edge, then score any write the port issued.
  task automatic tick();
    wrEntry_t e;
    @(posedge clk);
    #1;
    if (rfWen === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 64'(rfWaddr), 64'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 64'(rfWaddr), 64'(e.addr));
        checkOutput("wr_data", rfWdata, e.data);
      end
    end
  endtask

  // Main directed sequence.
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mdu_ready", 64'(mduReady), 64'd1);
    checkOutput("rst_rf_wen", 64'(rfWen), 64'd0);
    checkOutput("rst_rf_waddr", 64'(rfWaddr), 64'd0);
    checkOutput("rst_rf_wdata", rfWdata, 64'd0);
    checkOutput("rst_commit_valid", 64'(commitValid), 64'd0);
    checkOutput("rst_commit_pc", commitPc, 64'd0);
    reset = 1'b0;

    // Pipe-only write, granted on the first edge after reset release.
    applyStimulus(1'b1, 1'b1, 5'd5, 64'h11, 64'h8000_0000, 1'b0, 5'd0, 64'd0);
    checkOutput("s1_stall", 64'(pipeStall), 64'd0);
    expectWrite(5'd5, 64'h11);
    tick();
    checkOutput("s1_rf_wen", 64'(rfWen), 64'd1);
    checkOutput("s1_commit_valid", 64'(commitValid), 64'd1);
    checkOutput("s1_commit_pc", commitPc, 64'h8000_0000);
    idle();
    tick();
    checkOutput("s1_idle_wen", 64'(rfWen), 64'd0);
    checkOutput("s1_idle_hold_addr", 64'(rfWaddr), 64'd5);
    checkOutput("s1_idle_commit", 64'(commitValid), 64'd0);

    // An MDU push while the pipe is idle drains on the next cycle.
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd7, 64'hAA);
    checkOutput("s2_ready", 64'(mduReady), 64'd1);
    checkOutput("s2_busy_pre", 64'(busy), 64'd0);
    tick();
    idle();
    checkOutput("s2_busy", 64'(busy), 64'd1);
    expectWrite(5'd7, 64'hAA);
    tick();
    checkOutput("s2_rf_wen", 64'(rfWen), 64'd1);
    checkOutput("s2_busy_after", 64'(busy), 64'd0);

    // Hazard: buffered x9 must be written before the pipe's x9.
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 5'd9, 64'h33);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 64'h22, 64'h3000, 1'b0, 5'd0, 64'd0);
    checkOutput("s3_stall", 64'(pipeStall), 64'd1);
    expectWrite(5'd9, 64'h33);
    tick();
    checkOutput("s3_commit_stalled", 64'(commitValid), 64'd0);
    checkOutput("s3_stall_release", 64'(pipeStall), 64'd0);
    expectWrite(5'd9, 64'h22);
    tick();
    checkOutput("s3_commit_valid", 64'(commitValid), 64'd1);
    checkOutput("s3_commit_pc", commitPc, 64'h3000);

    // Starvation: x3 waits through three pipe wins, then forces a stall.
    applyStimulus(1'b1, 1'b1, 5'd20, 64'h55, 64'h3100, 1'b1, 5'd3, 64'h44);
    checkOutput("s4_stall_a", 64'(pipeStall), 64'd0);
    expectWrite(5'd20, 64'h55);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(10 + i), 64'(16'h10A + i), 64'(16'h3200 + 4 * i),
                    1'b0, 5'd0, 64'd0);
      checkOutput("s4_stall_pipe_win", 64'(pipeStall), 64'd0);
      expectWrite(5'(10 + i), 64'(16'h10A + i));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 5'd13, 64'h10D, 64'h320C, 1'b0, 5'd0, 64'd0);
    checkOutput("s4_stall_forced", 64'(pipeStall), 64'd1);
    expectWrite(5'd3, 64'h44);
    tick();
    checkOutput("s4_stall_after", 64'(pipeStall), 64'd0);
    expectWrite(5'd13, 64'h10D);
    tick();
    checkOutput("s4_busy_end", 64'(busy), 64'd0);

    // Three back-to-back MDU results against a saturated pipe.
    applyStimulus(1'b1, 1'b1, 5'd1, 64'h1000, 64'h2000, 1'b1, 5'd21, 64'hA1);
    checkOutput("s5_ready_c0", 64'(mduReady), 64'd1);
    expectWrite(5'd1, 64'h1000);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 64'h1001, 64'h2004, 1'b1, 5'd22, 64'hA2);
    checkOutput("s5_ready_c1", 64'(mduReady), 64'd1);
    expectWrite(5'd2, 64'h1001);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd4, 64'h1002, 64'h2008, 1'b1, 5'd23, 64'hA3);
    checkOutput("s5_ready_c2", 64'(mduReady), 64'd0);
    checkOutput("s5_stall_c2", 64'(pipeStall), 64'd0);
    expectWrite(5'd4, 64'h1002);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd5, 64'h1003, 64'h200C, 1'b1, 5'd23, 64'hA3);
    checkOutput("s5_ready_c3", 64'(mduReady), 64'd0);
    expectWrite(5'd5, 64'h1003);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd6, 64'h1004, 64'h2010, 1'b1, 5'd23, 64'hA3);
    checkOutput("s5_ready_c4", 64'(mduReady), 64'd0);
    checkOutput("s5_stall_c4", 64'(pipeStall), 64'd1);
    expectWrite(5'd21, 64'hA1);
    tick();
    checkOutput("s5_commit_c4", 64'(commitValid), 64'd0);
    checkOutput("s5_ready_c5", 64'(mduReady), 64'd1);
    checkOutput("s5_stall_c5", 64'(pipeStall), 64'd0);
    expectWrite(5'd6, 64'h1004);
    tick();
    checkOutput("s5_commit_c5", 64'(commitValid), 64'd1);
    idle();
    checkOutput("s5_busy_drain", 64'(busy), 64'd1);
    expectWrite(5'd22, 64'hA2);
    tick();
    expectWrite(5'd23, 64'hA3);
    tick();
    checkOutput("s5_busy_end", 64'(busy), 64'd0);

    // A FIFO entry for x0 pops silently while a non-writing pipe op commits.
    applyStimulus(1'b0, 1'b1, 5'd0, 64'd0, 64'd0, 1'b1, 5'd0, 64'h99);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd7, 64'h77, 64'h4000, 1'b0, 5'd0, 64'd0);
    checkOutput("s7_stall", 64'(pipeStall), 64'd0);
    tick();
    checkOutput("s7_rf_wen", 64'(rfWen), 64'd0);
    checkOutput("s7_busy", 64'(busy), 64'd0);
    checkOutput("s7_commit_valid", 64'(commitValid), 64'd1);
    checkOutput("s7_commit_pc", commitPc, 64'h4000);

    // A reset pulse with two buffered results discards both.
    applyStimulus(1'b1, 1'b1, 5'd1, 64'h5000, 64'h5000, 1'b1, 5'd24, 64'hB4);
    expectWrite(5'd1, 64'h5000);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 64'h5001, 64'h5004, 1'b1, 5'd25, 64'hB5);
    expectWrite(5'd2, 64'h5001);
    tick();
    checkOutput("s6_busy_full", 64'(busy), 64'd1);
    checkOutput("s6_ready_full", 64'(mduReady), 64'd0);
    reset = 1'b1;
    idle();
    checkOutput("s6_rst_busy", 64'(busy), 64'd0);
    checkOutput("s6_rst_ready", 64'(mduReady), 64'd1);
    checkOutput("s6_rst_wen", 64'(rfWen), 64'd0);
    checkOutput("s6_rst_commit", 64'(commitValid), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("s6_post_wen", 64'(rfWen), 64'd0);
      checkOutput("s6_post_busy", 64'(busy), 64'd0);
    end

    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
